// File: rtl/count_run_scheduler_pkg.sv
// Shared state encoding and default sizes for the count-run scheduler.
// Optional abort feature is controlled by COUNT_RUN_ABORT_EN (see the top).
package count_run_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/count_run_scheduler_if.sv
// Requester/status bundle between client logic and the count-run scheduler.
// COUNT_RUN_ABORT_EN adds the abort request and the done_abort status.
interface count_run_scheduler_if
    import count_run_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [NREQ-1:0]         req_valid;
    logic [NREQ*CNT_W-1:0]   req_len;
    logic [NREQ-1:0]         req_ready;
    logic                    busy;
    logic [CNT_W-1:0]        count;
    logic                    done;
    logic [$clog2(NREQ)-1:0] done_id;

`ifdef COUNT_RUN_ABORT_EN
    logic abort;
    logic done_abort;

    modport master (
        output req_valid, req_len, abort,
        input  req_ready, busy, count, done, done_id, done_abort
    );

    modport slave (
        input  req_valid, req_len, abort,
        output req_ready, busy, count, done, done_id, done_abort
    );
`else
    modport master (
        output req_valid, req_len,
        input  req_ready, busy, count, done, done_id
    );

    modport slave (
        input  req_valid, req_len,
        output req_ready, busy, count, done, done_id
    );
`endif

endinterface

// File: rtl/count_run_scheduler_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first request
// at or after ptr, wrapping modulo NREQ.
module rr_arbiter
    import count_run_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);

    localparam int PW = $clog2(NREQ);

    logic          found;
    logic [PW:0]   pos;

    // Walk the ring starting at ptr; one spare bit keeps ptr+offset from overflowing.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int off = 0; off < NREQ; off++) begin
            pos = {1'b0, ptr} + (PW+1)'(off);
            if (pos >= (PW+1)'(NREQ)) begin
                pos = pos - (PW+1)'(NREQ);
            end
            if (!found && req[pos[PW-1:0]]) begin
                gnt[pos[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_run_scheduler.sv
// Shares one up-counter between NREQ requesters, one run at a time (IDLE -> RUN -> DONE).
// Define COUNT_RUN_ABORT_EN to add the abort input and done_abort status.
module count_run_scheduler
    import count_run_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic                  clock,
    input logic                  reset,
    count_run_scheduler_if.slave bus
);

    localparam int PW = $clog2(NREQ);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [PW-1:0]    id_q;
    logic [PW-1:0]    ptr;
    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    gnt_id;
    logic [CNT_W-1:0] gnt_len;
    logic             accept;
    logic             last_count;
    logic             abort_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        gnt_id  = '0;
        gnt_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id  = PW'(i);
                gnt_len = bus.req_len[i*CNT_W +: CNT_W];
            end
        end
    end

    // Grants only exist in IDLE, and are forced low while reset is held.
    assign bus.req_ready = (state == ST_IDLE && reset) ? gnt : '0;
    assign accept        = (state == ST_IDLE) && (|gnt);
    assign last_count    = (cnt == len_q - CNT_W'(1));

`ifdef COUNT_RUN_ABORT_EN
    logic abort_q;

    assign abort_hit = bus.abort;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            abort_q <= 1'b0;
        end else if (accept) begin
            abort_q <= 1'b0;
        end else if (state == ST_RUN && bus.abort) begin
            abort_q <= 1'b1;
        end
    end

    assign bus.done_abort = (state == ST_DONE) && abort_q;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (gnt_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_hit || last_count) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter only advances while staying in RUN, so it freezes at len-1 or at the abort point.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            len_q <= '0;
            id_q  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt   <= '0;
                len_q <= gnt_len;
                id_q  <= gnt_id;
                ptr   <= (gnt_id == PW'(NREQ-1)) ? '0 : gnt_id + PW'(1);
            end else if (state == ST_RUN && state_next == ST_RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.count   = cnt;
    assign bus.done    = (state == ST_DONE);
    assign bus.done_id = id_q;

endmodule

// File: tb/tb_count_run_scheduler.sv
// Bench for count_run_scheduler: directed scenarios plus random traffic,
// every cycle compared against a run-timeline model of the scheduler.
module tb_count_run_scheduler;

    localparam int NR = 4;
    localparam int CW = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;

    count_run_scheduler_if #(.NREQ(NR), .CNT_W(CW)) bus ();

    count_run_scheduler #(.NREQ(NR), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cnt;
        bit done;
        int id;
        bit abrt;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    int          m_ptr = 0;
    int          m_hold = 0;
    logic [NR-1:0] acc_flag = '0;
    int          grant_log[$];
    int          done_log[$];
    int          last_acc_cyc = 0;
    int          last_done_cyc = 0;
    int          last_done_cnt = 0;
    int          last_done_abort = 0;
    int          done_pulses = 0;
    int          max_cnt = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic expect_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            failures++;
            $display("[TB] FAIL %s: condition false (cycle %0d)", name, cyc);
        end
    endtask

    function automatic exp_t mk(input int c, input bit d, input int id, input bit a);
        exp_t e;
        e.cnt  = c;
        e.done = d;
        e.id   = id;
        e.abrt = a;
        return e;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
        for (int off = 0; off < NR; off++) begin
            if (v[(ptr + off) % NR]) return (ptr + off) % NR;
        end
        return -1;
    endfunction

    function automatic int oh_index(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Model: an accepted run of length L expands into L counting cycles plus one done cycle.
    always @(negedge clock) begin
        exp_t e;
        int   w;
        int   len;
        cyc++;
        if (!reset) begin
            exp_q.delete();
            m_ptr  = 0;
            m_hold = 0;
            check_output("rst_ready", bus.req_ready, 0);
            check_output("rst_busy", bus.busy, 0);
            check_output("rst_count", bus.count, 0);
            check_output("rst_done", bus.done, 0);
`ifdef COUNT_RUN_ABORT_EN
            check_output("rst_done_abort", bus.done_abort, 0);
`endif
            acc_flag = '0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("ready_when_busy", bus.req_ready, 0);
                check_output("busy", bus.busy, 1);
                check_output("count", bus.count, e.cnt);
                check_output("done", bus.done, e.done);
                if (e.done) check_output("done_id", bus.done_id, e.id);
`ifdef COUNT_RUN_ABORT_EN
                check_output("done_abort", bus.done_abort, e.done ? e.abrt : 1'b0);
                if (bus.abort && !e.done) begin
                    exp_q.delete();
                    exp_q.push_back(mk(e.cnt, 1'b1, e.id, 1'b1));
                end
`endif
                m_hold = e.cnt;
            end else begin
                w = rr_pick(m_ptr, bus.req_valid);
                check_output("ready", bus.req_ready, (w < 0) ? 0 : (1 << w));
                check_output("idle_busy", bus.busy, 0);
                check_output("idle_count", bus.count, m_hold);
                check_output("idle_done", bus.done, 0);
`ifdef COUNT_RUN_ABORT_EN
                check_output("idle_done_abort", bus.done_abort, 0);
`endif
                if (w >= 0) begin
                    len = int'(bus.req_len[w*CW +: CW]);
                    for (int t = 0; t < len; t++) exp_q.push_back(mk(t, 1'b0, w, 1'b0));
                    exp_q.push_back(mk((len == 0) ? 0 : len - 1, 1'b1, w, 1'b0));
                    m_ptr = (w + 1) % NR;
                end
            end
            acc_flag = bus.req_valid & bus.req_ready;
            if (|acc_flag) begin
                last_acc_cyc = cyc;
                grant_log.push_back(oh_index(acc_flag));
            end
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        end
        if (bus.done === 1'b1) begin
            done_pulses++;
            last_done_cyc = cyc;
            last_done_cnt = int'(bus.count);
            done_log.push_back(int'(bus.done_id));
`ifdef COUNT_RUN_ABORT_EN
            last_done_abort = int'(bus.done_abort);
`endif
        end
    end

    task automatic apply_stimulus();
        @(posedge clock);
        #1;
        bus.req_valid = bus.req_valid & ~acc_flag;
    endtask

    task automatic set_req(input int i, input int len);
        bus.req_len[i*CW +: CW] = CW'(len);
        bus.req_valid[i]        = 1'b1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        done_log.delete();
        max_cnt = 0;
    endtask

    task automatic wait_dones(input int n, input int limit, input string name);
        int target;
        target = done_pulses + n;
        for (int c = 0; c < limit && done_pulses < target; c++) apply_stimulus();
        expect_true(name, done_pulses >= target);
    endtask

    task automatic wait_count(input int value, input int limit, input string name);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < limit && !hit; c++) begin
            apply_stimulus();
            hit = bus.busy && (int'(bus.count) == value);
        end
        expect_true(name, hit);
    endtask

    task automatic wait_idle(input int limit, input string name);
        for (int c = 0; c < limit && bus.busy; c++) apply_stimulus();
        apply_stimulus();
        expect_true(name, !bus.busy);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        int n0;
        bus.req_valid = '0;
        bus.req_len   = '0;
`ifdef COUNT_RUN_ABORT_EN
        bus.abort = 1'b0;
`endif
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        check_output("init_busy", bus.busy, 0);
        check_output("init_count", bus.count, 0);
        check_output("init_done", bus.done, 0);
        check_output("init_ready", bus.req_ready, 0);

        // Reset in the middle of a run: immediate clear, no done pulse.
        set_req(2, 10);
        wait_count(3, 30, "t1_reach_count3");
        n0 = done_pulses;
        #2 reset = 1'b0;
        #1;
        check_output("t1_async_count", bus.count, 0);
        check_output("t1_async_busy", bus.busy, 0);
        check_output("t1_async_done", bus.done, 0);
        check_output("t1_async_ready", bus.req_ready, 0);
        repeat (2) @(posedge clock);
        #1;
        check_output("t1_ready_held_low", bus.req_ready, 0);
        bus.req_valid = '0;
        reset = 1'b1;
        repeat (12) apply_stimulus();
        check_output("t1_no_done", done_pulses, n0);

        // All four contend with pointer at 0.
        clear_logs();
        for (int i = 0; i < NR; i++) set_req(i, 2);
        wait_dones(4, 60, "t3_timeout");
        check_output("t3_grants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check_output("t3_grant_order", grant_log[i], i);
        for (int i = 0; i < 4 && i < done_log.size(); i++) check_output("t3_done_id_order", done_log[i], i);

        // Single run of length 5.
        clear_logs();
        set_req(0, 5);
        wait_dones(1, 20, "t2_timeout");
        check_output("t2_latency", last_done_cyc - last_acc_cyc, 6);
        check_output("t2_done_count", last_done_cnt, 4);
        if (done_log.size() > 0) check_output("t2_done_id", done_log[0], 0);
        check_output("t2_count_held", bus.count, 4);

        // Zero and maximum lengths.
        clear_logs();
        set_req(1, 0);
        wait_dones(1, 10, "t4_zero_timeout");
        check_output("t4_zero_latency", last_done_cyc - last_acc_cyc, 1);
        check_output("t4_zero_count", last_done_cnt, 0);
        clear_logs();
        set_req(2, 63);
        wait_dones(1, 80, "t4_max_timeout");
        check_output("t4_max_latency", last_done_cyc - last_acc_cyc, 64);
        check_output("t4_max_done_count", last_done_cnt, 62);
        check_output("t4_max_peak", max_cnt, 62);

        // Fairness between two persistent requesters.
        do_reset();
        clear_logs();
        set_req(1, 1);
        set_req(3, 1);
        for (int c = 0; c < 60 && grant_log.size() < 4; c++) begin
            apply_stimulus();
            bus.req_valid = bus.req_valid | 4'b1010;
        end
        bus.req_valid = '0;
        check_output("t5_grants", grant_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check_output("t5_alternate", grant_log[i], (i % 2 == 0) ? 1 : 3);
        wait_idle(20, "t5_drain");

`ifdef COUNT_RUN_ABORT_EN
        clear_logs();
        set_req(0, 10);
        wait_count(4, 30, "t6_reach_count4");
        bus.abort = 1'b1;
        apply_stimulus();
        bus.abort = 1'b0;
        wait_dones(1, 10, "t6_timeout");
        check_output("t6_abort_count", last_done_cnt, 4);
        check_output("t6_done_abort", last_done_abort, 1);
        check_output("t6_latency", last_done_cyc - last_acc_cyc, 6);
`else
        clear_logs();
        set_req(0, 10);
        wait_dones(1, 20, "t6_timeout");
        check_output("t6_full_count", last_done_cnt, 9);
        check_output("t6_latency", last_done_cyc - last_acc_cyc, 11);
`endif

        // Random traffic, with occasional aborts and asynchronous resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus();
            for (int i = 0; i < NR; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 63)));
                end
            end
`ifdef COUNT_RUN_ABORT_EN
            bus.abort = ($urandom_range(0, 15) == 0);
`endif
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b0;
                @(posedge clock);
                #1 reset = 1'b1;
            end
        end
        bus.req_valid = '0;
`ifdef COUNT_RUN_ABORT_EN
        bus.abort = 1'b0;
`endif
        wait_idle(80, "rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
